// File: rtl/connect4_pkg.sv
// Shared Connect-4 board dimensions, FSM state, player and winner encodings.
package connect4_pkg;

  localparam int unsigned COLS   = 7;
  localparam int unsigned ROWS   = 6;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned MOVES  = COLS * ROWS;
  localparam int unsigned MOVE_W = $clog2(MOVES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MOVE,
    WRITE,
    CHECK,
    DONE
  } state_t;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

endpackage

// File: rtl/turn_timer.sv
// Turn timer: counts cycles while enabled, pulses expire on the
// TIMEOUT_CYCLES-th enabled cycle after a load. Built only with TURN_TIMEOUT_EN.
`ifdef TURN_TIMEOUT_EN
module turn_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Counter with look-ahead compare so expire is registered yet lands on count TIMEOUT_CYCLES-1
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (en) begin
      cnt    <= cnt + CNT_W'(1);
      expire <= (cnt == CNT_W'(TIMEOUT_CYCLES - 2));
    end
  end

endmodule
`endif

// File: rtl/turn_arbiter.sv
// Connect-4 turn sequencer: accepts the active player's column, issues one
// board write per accepted move, waits for the win checker, alternates turns.
// Optional turn timeout with automatic move: define TURN_TIMEOUT_EN.
module turn_arbiter
  import connect4_pkg::*;
`ifdef TURN_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             p1_valid,
  input  logic [COL_W-1:0] p1_col,
  input  logic             p2_valid,
  input  logic [COL_W-1:0] p2_col,
  input  logic             check_done,
  input  logic             win,
  output logic             turn,
  output logic             wr_en,
  output logic [COL_W-1:0] wr_col,
  output logic [ROW_W-1:0] wr_row,
  output logic             wr_player,
  output logic [COLS-1:0]  col_full,
  output logic             bad_move,
  output logic             timeout,
  output logic             game_done,
  output logic [1:0]       winner
);

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    height_q [COLS];
  logic [ROW_W-1:0]    height_d [COLS];
  logic [MOVE_W-1:0]   moves_q, moves_d;

  logic                turn_d, wr_en_d, wr_player_d, bad_move_d, timeout_d, game_done_d;
  logic [COL_W-1:0]    wr_col_d;
  logic [ROW_W-1:0]    wr_row_d;
  logic [COLS-1:0]     col_full_d;
  logic [1:0]          winner_d;

  logic                req_valid, req_legal;
  logic [COL_W-1:0]    req_col, force_col;
  logic [ROW_W-1:0]    req_row, force_row;
  logic                expire;

`ifdef TURN_TIMEOUT_EN
  // Timer reloads whenever the FSM is outside WAIT_MOVE, i.e. on every turn entry
  turn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_turn_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (state_q != WAIT_MOVE),
    .en    (state_q == WAIT_MOVE),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  // Active player's request, its legality and landing row; lowest open column for forced moves
  always_comb begin
    req_valid = (turn == P2) ? p2_valid : p1_valid;
    req_col   = (turn == P2) ? p2_col : p1_col;
    req_legal = 1'b0;
    req_row   = '0;
    force_col = '0;
    force_row = '0;
    for (int c = 0; c < int'(COLS); c++) begin
      if (req_col == COL_W'(c)) begin
        req_legal = !col_full[c];
        req_row   = height_q[c];
      end
    end
    for (int c = int'(COLS) - 1; c >= 0; c--) begin
      if (!col_full[c]) begin
        force_col = COL_W'(c);
        force_row = height_q[c];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    height_d    = height_q;
    moves_d     = moves_q;
    turn_d      = turn;
    wr_en_d     = 1'b0;
    wr_col_d    = wr_col;
    wr_row_d    = wr_row;
    wr_player_d = wr_player;
    col_full_d  = col_full;
    bad_move_d  = 1'b0;
    timeout_d   = 1'b0;
    game_done_d = game_done;
    winner_d    = winner;

    unique case (state_q)
      IDLE: begin
        height_d = '{default: '0};
        moves_d  = '0;
        if (start) begin
          state_d = WAIT_MOVE;
          turn_d  = P1;
        end
      end

      WAIT_MOVE: begin
        if (expire) begin
          state_d     = WRITE;
          timeout_d   = 1'b1;
          wr_en_d     = 1'b1;
          wr_col_d    = force_col;
          wr_row_d    = force_row;
          wr_player_d = turn;
        end else if (req_valid) begin
          if (req_legal) begin
            state_d     = WRITE;
            wr_en_d     = 1'b1;
            wr_col_d    = req_col;
            wr_row_d    = req_row;
            wr_player_d = turn;
          end else begin
            bad_move_d = 1'b1;
          end
        end
      end

      WRITE: begin
        moves_d = moves_q + MOVE_W'(1);
        for (int c = 0; c < int'(COLS); c++) begin
          if (wr_col == COL_W'(c)) begin
            height_d[c]   = height_q[c] + ROW_W'(1);
            col_full_d[c] = (height_q[c] == ROW_W'(ROWS - 1));
          end
        end
        state_d = CHECK;
      end

      CHECK: begin
        if (check_done) begin
          if (win) begin
            winner_d    = (turn == P2) ? WIN_P2 : WIN_P1;
            game_done_d = 1'b1;
            state_d     = DONE;
          end else if (moves_q == MOVE_W'(MOVES)) begin
            winner_d    = WIN_DRAW;
            game_done_d = 1'b1;
            state_d     = DONE;
          end else begin
            turn_d  = ~turn;
            state_d = WAIT_MOVE;
          end
        end
      end

      DONE: begin
        if (start) begin
          height_d    = '{default: '0};
          moves_d     = '0;
          col_full_d  = '0;
          winner_d    = WIN_NONE;
          game_done_d = 1'b0;
          turn_d      = P1;
          state_d     = WAIT_MOVE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, board bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      height_q  <= '{default: '0};
      moves_q   <= '0;
      turn      <= P1;
      wr_en     <= 1'b0;
      wr_col    <= '0;
      wr_row    <= '0;
      wr_player <= 1'b0;
      col_full  <= '0;
      bad_move  <= 1'b0;
      timeout   <= 1'b0;
      game_done <= 1'b0;
      winner    <= WIN_NONE;
    end else begin
      state_q   <= state_d;
      height_q  <= height_d;
      moves_q   <= moves_d;
      turn      <= turn_d;
      wr_en     <= wr_en_d;
      wr_col    <= wr_col_d;
      wr_row    <= wr_row_d;
      wr_player <= wr_player_d;
      col_full  <= col_full_d;
      bad_move  <= bad_move_d;
      timeout   <= timeout_d;
      game_done <= game_done_d;
      winner    <= winner_d;
    end
  end

endmodule

// File: tb/tb_turn_arbiter.sv
// Bench for turn_arbiter: directed steps plus random games against a
// board-level reference model. Timeout steps run when TURN_TIMEOUT_EN is defined.
module tb_turn_arbiter;

  localparam int PH_IDLE  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_CHECK = 2;
  localparam int PH_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst, start, p1_valid, p2_valid, check_done, win;
  logic [2:0] p1_col, p2_col;
  logic       turn, wr_en, wr_player, bad_move, timeout, game_done;
  logic [2:0] wr_col, wr_row;
  logic [6:0] col_full;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;

  // Reference model: column heights, move count, whose turn, phase, result
  int hts [7];
  int nmoves, mturn, phase, mwinner, idle_turn;

  always #5 clk = ~clk;

`ifdef TURN_TIMEOUT_EN
  turn_arbiter #(.TIMEOUT_CYCLES(16)) dut (
`else
  turn_arbiter dut (
`endif
    .clk(clk), .rst(rst), .start(start),
    .p1_valid(p1_valid), .p1_col(p1_col),
    .p2_valid(p2_valid), .p2_col(p2_col),
    .check_done(check_done), .win(win),
    .turn(turn), .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row),
    .wr_player(wr_player), .col_full(col_full), .bad_move(bad_move),
    .timeout(timeout), .game_done(game_done), .winner(winner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] model_full();
    logic [6:0] f;
    f = '0;
    for (int c = 0; c < 7; c++) if (hts[c] == 6) f[c] = 1'b1;
    return f;
  endfunction

  function automatic int pick_legal();
    int c;
    c = int'($urandom_range(0, 6));
    for (int k = 0; k < 7; k++) begin
      if (hts[c] < 6) return c;
      c = (c + 1) % 7;
    end
    return 0;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 7; c++) hts[c] = 0;
    nmoves = 0; mturn = 0; mwinner = 0; idle_turn = 0;
  endtask

  task automatic chk_reset();
    chk("rst_turn", 32'(turn), 32'(0));
    chk("rst_wr_en", 32'(wr_en), 32'(0));
    chk("rst_wr_col", 32'(wr_col), 32'(0));
    chk("rst_wr_row", 32'(wr_row), 32'(0));
    chk("rst_wr_player", 32'(wr_player), 32'(0));
    chk("rst_col_full", 32'(col_full), 32'(0));
    chk("rst_bad_move", 32'(bad_move), 32'(0));
    chk("rst_timeout", 32'(timeout), 32'(0));
    chk("rst_game_done", 32'(game_done), 32'(0));
    chk("rst_winner", 32'(winner), 32'(0));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (phase == PH_IDLE || phase == PH_DONE) begin
      model_clear();
      phase = PH_WAIT;
    end
    chk("start_turn", 32'(turn), 32'(mturn));
    chk("start_game_done", 32'(game_done), 32'(phase == PH_DONE));
    chk("start_winner", 32'(winner), 32'(mwinner));
    chk("start_col_full", 32'(col_full), 32'(model_full()));
  endtask

  // Pulse one player's request; spoof drives check_done/win during the WRITE cycle
  task automatic pulse_move(input int p, input int c, input bit spoof);
    bit act, legal;
    if (p == 1) begin p1_valid = 1'b1; p1_col = 3'(c); end
    else        begin p2_valid = 1'b1; p2_col = 3'(c); end
    @(posedge clk); #1;
    p1_valid = 1'b0; p2_valid = 1'b0;
    act   = (phase == PH_WAIT) && (p - 1 == mturn);
    legal = 1'b0;
    if (act && c < 7) legal = (hts[c] < 6);
    chk("wr_en", 32'(wr_en), 32'(legal));
    chk("bad_move", 32'(bad_move), 32'(act && !legal));
    chk("timeout_quiet", 32'(timeout), 32'(0));
    chk("turn_hold", 32'(turn), 32'(mturn));
    if (legal) begin
      chk("wr_col", 32'(wr_col), 32'(c));
      chk("wr_row", 32'(wr_row), 32'(hts[c]));
      chk("wr_player", 32'(wr_player), 32'(mturn));
      hts[c]++; nmoves++;
      phase = PH_CHECK; idle_turn = 0;
      if (spoof) begin check_done = 1'b1; win = 1'b1; end
      @(posedge clk); #1;
      check_done = 1'b0; win = 1'b0;
      chk("wr_en_pulse", 32'(wr_en), 32'(0));
      chk("col_full", 32'(col_full), 32'(model_full()));
      chk("no_early_done", 32'(game_done), 32'(0));
    end else if (phase == PH_WAIT) begin
      idle_turn++;
    end
  endtask

  task automatic do_check(input bit w, input int gap);
    for (int k = 0; k < gap; k++) @(posedge clk);
    #1;
    check_done = 1'b1; win = w;
    @(posedge clk); #1;
    check_done = 1'b0; win = 1'b0;
    if (w) begin
      mwinner = (mturn == 1) ? 2 : 1; phase = PH_DONE;
    end else if (nmoves == 42) begin
      mwinner = 3; phase = PH_DONE;
    end else begin
      mturn = 1 - mturn; phase = PH_WAIT; idle_turn = 0;
    end
    chk("chk_turn", 32'(turn), 32'(mturn));
    chk("chk_game_done", 32'(game_done), 32'(phase == PH_DONE));
    chk("chk_winner", 32'(winner), 32'(mwinner));
  endtask

  initial begin
    int p, c;
    rst = 1'b1; start = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0;
    p1_col = '0; p2_col = '0; check_done = 1'b0; win = 1'b0;
    model_clear(); phase = PH_IDLE;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;

    // Basic turn, wrong-turn request, check_done during WRITE ignored
    do_start();
    pulse_move(2, 2, 1'b0);
    pulse_move(1, 4, 1'b1);
    // Requests and start during CHECK are dropped
    p1_valid = 1'b1; p1_col = 3'd3;
    @(posedge clk); #1;
    p1_valid = 1'b0;
    chk("check_drop_wr_en", 32'(wr_en), 32'(0));
    chk("check_drop_bad", 32'(bad_move), 32'(0));
    do_start();
    do_check(1'b0, 1);
    pulse_move(2, 4, 1'b0);
    do_check(1'b0, 0);

    // Fill column 0, then reject full column and out-of-range column
    for (int k = 0; k < 6; k++) begin
      pulse_move(1 + mturn, 0, 1'b0);
      do_check(1'b0, 0);
    end
    pulse_move(1 + mturn, 0, 1'b0);
    pulse_move(1 + mturn, 7, 1'b0);

    // P2 win, moves ignored in DONE, restart clears heights
    if (mturn == 0) begin
      pulse_move(1, 5, 1'b0);
      do_check(1'b0, 0);
    end
    pulse_move(2, 5, 1'b0);
    do_check(1'b1, 2);
    pulse_move(1, 3, 1'b0);
    do_start();
    pulse_move(1, 4, 1'b0);
    do_check(1'b0, 0);

    // Draw: random legal moves until the board is full
    for (int it = 0; it < 60 && phase != PH_DONE; it++) begin
      pulse_move(1 + mturn, pick_legal(), 1'b0);
      do_check(1'b0, int'($urandom_range(0, 2)));
    end
    chk("draw_winner", 32'(winner), 32'(3));

    // Random games: stray requests, bad columns, occasional wins
    for (int g = 0; g < 3; g++) begin
      do_start();
      for (int it = 0; it < 600 && phase != PH_DONE; it++) begin
        if (idle_turn >= 8) begin
          p = 1 + mturn; c = pick_legal();
        end else if ($urandom_range(0, 3) != 0) begin
          p = 1 + mturn; c = int'($urandom_range(0, 7));
        end else begin
          p = 2 - mturn; c = int'($urandom_range(0, 7));
        end
        pulse_move(p, c, 1'b0);
        if (phase == PH_CHECK) do_check($urandom_range(0, 40) == 0, int'($urandom_range(0, 3)));
      end
    end

`ifdef TURN_TIMEOUT_EN
    // Timeout with column 0 full forces column 1; then reset mid-CHECK
    do_start();
    for (int k = 0; k < 6; k++) begin
      pulse_move(1 + mturn, 0, 1'b0);
      do_check(1'b0, 0);
    end
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      chk("to_early_timeout", 32'(timeout), 32'(0));
      chk("to_early_wr_en", 32'(wr_en), 32'(0));
    end
    @(posedge clk); #1;
    chk("to_timeout", 32'(timeout), 32'(1));
    chk("to_wr_en", 32'(wr_en), 32'(1));
    chk("to_wr_col", 32'(wr_col), 32'(1));
    chk("to_wr_row", 32'(wr_row), 32'(hts[1]));
    chk("to_wr_player", 32'(wr_player), 32'(mturn));
    hts[1]++; nmoves++; phase = PH_CHECK;
    @(posedge clk); #1;
    chk("to_pulse", 32'(timeout), 32'(0));
    chk("to_col_full", 32'(col_full), 32'(model_full()));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear(); phase = PH_IDLE;
    chk_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/turn_arbiter.md
# turn_arbiter

Sequences a two-player Connect-4 match on the 7×6 board. It accepts column requests from the Player 1 and Player 2 input blocks, but only from the player whose turn it is. It rejects moves into illegal or full columns, tracks column heights, and issues one board-write per accepted move. It then waits for the win checker, alternates turns, and optionally forces an automatic move on turn timeout. It sits between the player input modules and the board memory / win-check logic in the game top level.

## Interface
- `COLS`, 7: board columns; column index width is 3 bits.
- `ROWS`, 6: board rows; row index width is 3 bits.
- `TIMEOUT_CYCLES`, 500_000_000: turn time limit in clk cycles (10 s at 50 MHz); only used with the timeout macro.
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that starts a new match.
- `p1_valid` in 1: single-cycle move pulse from Player 1.
- `p1_col` in 3: Player 1 column, qualified by `p1_valid`.
- `p2_valid` in 1: single-cycle move pulse from Player 2.
- `p2_col` in 3: Player 2 column, qualified by `p2_valid`.
- `check_done` in 1: pulse from the win checker meaning evaluation of the last write is complete.
- `win` in 1: win-checker result, sampled only when `check_done` is high.
- `turn` out 1: 0 = Player 1, 1 = Player 2.
- `wr_en` out 1: single-cycle board-write strobe.
- `wr_col` out 3: column of the write.
- `wr_row` out 3: row of the write; 0 is the bottom row.
- `wr_player` out 1: player owning the written cell.
- `col_full` out COLS: bit c is high when column c holds ROWS pieces.
- `bad_move` out 1: single-cycle pulse on a rejected request from the active player.
- `timeout` out 1: single-cycle pulse when an automatic move is forced.
- `game_done` out 1: level; match has ended.
- `winner` out 2: 00 none, 01 P1, 10 P2, 11 draw.

## Operation
- FSM states: IDLE, WAIT_MOVE, WRITE, CHECK, DONE.
- **IDLE**
  - Heights and move count are held at 0.
  - On `start`: go to WAIT_MOVE with `turn`=0.
- **WAIT_MOVE**
  - Only the active player's valid/col pair is examined; the other player's pulses are ignored silently.
  - Accepted request (col < COLS and not `col_full[col]`): latch col and go to WRITE.
  - Rejected request: pulse `bad_move` and stay in WAIT_MOVE; the turn timer is not reset.
  - If both valid inputs rise in the same cycle, only the active player counts.
- **WRITE**, one cycle:
  - `wr_en`=1, `wr_col`=latched col, `wr_row`=height[col], `wr_player`=`turn`.
  - height[col] and the move count increment.
  - Go to CHECK.
- **CHECK**
  - Wait for `check_done`.
  - If `win`=1: `winner` = 01 or 10 according to `turn`; go to DONE.
  - Else if move count = COLS*ROWS: `winner`=11; go to DONE.
  - Otherwise toggle `turn` and go to WAIT_MOVE.
  - `pX_valid` inputs arriving during CHECK are dropped.
- **DONE**
  - `game_done`=1; all moves are ignored.
  - `start` clears all state and re-enters WAIT_MOVE with `turn`=0.
- `start` received outside IDLE and DONE is ignored.

## Timing
- Reset values: `turn`=0, `wr_en`=0, `wr_col`=0, `wr_row`=0, `wr_player`=0, `col_full`=0, `bad_move`=0, `timeout`=0, `game_done`=0, `winner`=00. State is IDLE and all heights are 0.
- All outputs are registered.
- A valid pulse sampled at edge N produces `wr_en` high during cycle N+1.
- `col_full` updates in the cycle after the WRITE.
- `turn` toggles in the cycle after `check_done`.
- The earliest the next move can be accepted is 1 cycle after the toggle.
- `rst` takes effect at the next edge from any state, including a mid-WRITE cycle; no partial write is held afterwards.
- A `check_done` seen in the same cycle as the WRITE is not valid; only CHECK samples it.

## Configuration
- `TURN_TIMEOUT_EN` defined:
  - A timer counts cycles in WAIT_MOVE and reloads on every turn entry.
  - When it reaches TIMEOUT_CYCLES−1: pulse `timeout` and force a move into the lowest-index non-full column. The forced move goes through WRITE exactly like an accepted move.
- `TURN_TIMEOUT_EN` undefined:
  - No timer logic is built; WAIT_MOVE waits indefinitely.
  - `timeout` is tied to 0.

## Structure
- Package `connect4_pkg` holds:
  - COLS, ROWS, and the column/row index widths.
  - The `state_t` enum.
  - The `player_t` enum (P1=0, P2=1).
  - The `winner_t` encoding.
- Sub-module `turn_timer` (exists only under `TURN_TIMEOUT_EN`):
  - Inputs: clk, rst, load, en.
  - Output: expire pulse.
  - TIMEOUT_CYCLES is passed down as a parameter.

## Test plan
- Basic turn: `start`, then P1 col 4 → `wr_en` with col 4, row 0, player 0. `check_done` with `win`=0 → `turn`=1. P2 col 4 → row 1, player 1.
- Wrong-turn request: while `turn`=0, P2 col 2 → no `wr_en` and no `bad_move`; P2's column height stays 0.
- Full column: 6 alternating moves into col 0 → `col_full[0]`=1. Next request for col 0 → `bad_move` pulse with `turn` unchanged. Request for col 7 → `bad_move`.
- Win: `check_done` with `win`=1 on a P2 write → `winner`=10, `game_done`=1. Further `p1_valid` pulses are ignored. `start` → heights 0, `turn`=0.
- Draw: 42 legal moves with `win`=0 every time → `winner`=11 after the 42nd `check_done`.
- Timeout (`TURN_TIMEOUT_EN`, TIMEOUT_CYCLES=16, col 0 full): 16 idle cycles → `timeout` pulse, then `wr_en` at col 1. A mid-CHECK `rst` afterwards → every output at its reset value on the next edge.
